// File: rtl/hilo_defs.sv
// Shared definitions for the HI/LO multiply/divide unit: operation codes,
// controller state encodings and the divider iteration count.
package hilo_defs;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MUL     = 2'd1,
    ST_DIV     = 2'd2,
    ST_DIV_FIX = 2'd3
  } state_e;

  // One restoring step per quotient bit.
  localparam int         DIV_ITERS = 32;
  localparam logic [4:0] DIV_LAST  = 5'(DIV_ITERS - 1);

  // Two's-complement negate when neg is set: used both to take magnitudes
  // and to put signs back on the unsigned quotient/remainder.
  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
    return neg ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/div_iter.sv
// One unsigned restoring radix-2 division step. The quotient register also
// carries the not-yet-consumed dividend bits, shifting out at the top while
// new quotient bits shift in at the bottom.
module div_iter (
  input  logic [31:0] rem,
  input  logic [31:0] quo,
  input  logic [31:0] dvs,
  output logic [31:0] rem_next,
  output logic [31:0] quo_next
);

  logic [32:0] shifted_s;
  logic [32:0] diff_s;

  // Trial subtract; keep the difference only if it did not borrow.
  always_comb begin
    shifted_s = {rem, quo[31]};
    diff_s    = shifted_s - {1'b0, dvs};
    if (!diff_s[32]) begin
      rem_next = diff_s[31:0];
      quo_next = {quo[30:0], 1'b1};
    end else begin
      rem_next = shifted_s[31:0];
      quo_next = {quo[30:0], 1'b0};
    end
  end

endmodule

// File: rtl/hilo_unit_ctrl.sv
// HI/LO unit controller: single-cycle-issue multiply, 32-step restoring
// divide with sign fix-up, and direct moves into HI/LO.
module hilo_unit_ctrl
  import hilo_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_e      state_r;
  logic        busy_r;
  logic        done_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic [31:0] op_a_r;
  logic [31:0] op_b_r;
  logic        signed_r;
  logic [31:0] rem_r;
  logic [31:0] quo_r;
  logic [31:0] dvs_r;
  logic [4:0]  cnt_r;
  logic        q_neg_r;
  logic        r_neg_r;

  logic [63:0] ext_a_s;
  logic [63:0] ext_b_s;
  logic [63:0] prod_s;
  logic        a_neg_s;
  logic        b_neg_s;
  logic [31:0] rem_next_s;
  logic [31:0] quo_next_s;

  // Sign-extend (MULT) or zero-extend (MULTU); the low 64 bits of the
  // 64x64 product are then correct for both cases.
  always_comb begin
    ext_a_s = {(signed_r ? {32{op_a_r[31]}} : 32'h0000_0000), op_a_r};
    ext_b_s = {(signed_r ? {32{op_b_r[31]}} : 32'h0000_0000), op_b_r};
    prod_s  = ext_a_s * ext_b_s;
  end

  // Operand signs only matter for signed DIV; DIVU treats both as positive.
  always_comb begin
    if (op == OP_DIV) begin
      a_neg_s = a[31];
      b_neg_s = b[31];
    end else begin
      a_neg_s = 1'b0;
      b_neg_s = 1'b0;
    end
  end

  div_iter u_div_iter (
    .rem      (rem_r),
    .quo      (quo_r),
    .dvs      (dvs_r),
    .rem_next (rem_next_s),
    .quo_next (quo_next_s)
  );

  // Controller FSM with all outputs and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      hi_r     <= 32'h0000_0000;
      lo_r     <= 32'h0000_0000;
      op_a_r   <= 32'h0000_0000;
      op_b_r   <= 32'h0000_0000;
      signed_r <= 1'b0;
      rem_r    <= 32'h0000_0000;
      quo_r    <= 32'h0000_0000;
      dvs_r    <= 32'h0000_0000;
      cnt_r    <= 5'd0;
      q_neg_r  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (op_valid && (op <= OP_MTLO)) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                op_a_r   <= a;
                op_b_r   <= b;
                signed_r <= (op == OP_MULT);
                state_r  <= ST_MUL;
                busy_r   <= 1'b1;
              end
              OP_DIV, OP_DIVU: begin
                if (b == 32'h0000_0000) begin
                  // Divide by zero: HI/LO untouched, just acknowledge.
                  done_r <= 1'b1;
                end else begin
                  quo_r   <= neg_if(a, a_neg_s);
                  dvs_r   <= neg_if(b, b_neg_s);
                  rem_r   <= 32'h0000_0000;
                  cnt_r   <= 5'd0;
                  q_neg_r <= a_neg_s ^ b_neg_s;
                  r_neg_r <= a_neg_s;
                  state_r <= ST_DIV;
                  busy_r  <= 1'b1;
                end
              end
              OP_MTHI: begin
                hi_r   <= a;
                done_r <= 1'b1;
              end
              OP_MTLO: begin
                lo_r   <= a;
                done_r <= 1'b1;
              end
              default: begin
                done_r <= 1'b0;
              end
            endcase
          end
        end
        ST_MUL: begin
          hi_r    <= prod_s[63:32];
          lo_r    <= prod_s[31:0];
          done_r  <= 1'b1;
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        ST_DIV: begin
          rem_r <= rem_next_s;
          quo_r <= quo_next_s;
          cnt_r <= cnt_r + 5'd1;
          if (cnt_r == DIV_LAST) begin
            state_r <= ST_DIV_FIX;
          end
        end
        ST_DIV_FIX: begin
          lo_r    <= neg_if(quo_r, q_neg_r);
          hi_r    <= neg_if(rem_r, r_neg_r);
          done_r  <= 1'b1;
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: doc/hilo_unit_ctrl.md
HILO_UNIT_CTRL -- requirements
Module: hilo_unit_ctrl

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have port op_valid, input, 1 bit: an operation request is present this cycle.
REQ-004 The block SHALL have port op, input, 3 bits, with the following encodings:
- 0 MULT
- 1 MULTU
- 2 DIV
- 3 DIVU
- 4 MTHI
- 5 MTLO
- 6, 7 reserved
REQ-005 The block SHALL have port a, input, 32 bits: rs operand (dividend/multiplicand/move source).
REQ-006 The block SHALL have port b, input, 32 bits: rt operand (divisor/multiplier).
REQ-007 The block SHALL have port busy, output, 1 bit: operation in flight; pipeline stalls MFHI/MFLO and new HI/LO ops while high.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse when HI/LO hold a completed result.
REQ-009 The block SHALL have port hi, output, 32 bits: HI register value.
REQ-010 The block SHALL have port lo, output, 32 bits: LO register value.

Function
REQ-011 A request SHALL be accepted at a rising edge where op_valid=1, busy=0 and op≤5; requests with busy=1 or op 6/7 SHALL be ignored with no state change.
REQ-012 The FSM SHALL have states IDLE, MUL, DIV, DIV_FIX; busy=1 exactly when state≠IDLE.
REQ-013 On an accepted MULT/MULTU, the block SHALL register a, b and the signedness flag and enter MUL.
REQ-014 In MUL, the block SHALL form the 64-bit product of the registered operands (signed for MULT, unsigned for MULTU), write {hi,lo} at the closing edge and return to IDLE; latency is 2 edges from acceptance to the new hi/lo, with busy high for 1 cycle.
REQ-015 On an accepted DIV/DIVU with b≠0, the block SHALL latch |a|, |b| (raw values for DIVU) and the result signs, clear a 5-bit iteration counter and enter DIV.
REQ-016 DIV SHALL perform one restoring radix-2 step per cycle for 32 cycles (counter 0..31), then enter DIV_FIX.
REQ-017 DIV_FIX SHALL apply signs per these rules, write hi/lo and return to IDLE; busy is high for 33 cycles:
- quotient negative iff operand signs differ
- remainder takes the dividend's sign
- lo=quotient, hi=remainder
REQ-018 Signed DIV 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000, hi=0x00000000 with no special path beyond the 32-bit wrap.
REQ-019 DIV/DIVU with b=0 SHALL leave hi and lo unchanged, never assert busy, and pulse done one cycle after acceptance.
REQ-020 MTHI/MTLO SHALL write a into hi/lo at the acceptance edge, never assert busy, and pulse done in the following cycle.
REQ-021 done SHALL be registered, high exactly in the first cycle hi/lo show the new value, and never high for ignored requests.
REQ-022 hi/lo SHALL be stable at all times except at the completing edge of an operation.

Reset
REQ-023 When rst=1 at a clock edge, the block SHALL set state=IDLE, busy=0, done=0, hi=0, lo=0, the counter to 0 and the operand registers to 0.
REQ-024 Reset mid-operation SHALL abort the operation with no partial write to hi/lo, and the block SHALL accept a new request on the first edge after rst deasserts.
REQ-025 An op_valid concurrent with rst=1 SHALL be discarded.

Structure
REQ-026 The shared header hilo_defs SHALL hold the op encodings, FSM state encodings and the iteration count constant (32).
REQ-027 The single sub-module div_iter SHALL implement the unsigned restoring step, taking remainder, quotient and divisor and returning the next remainder/quotient.
REQ-028 Sign handling and the FSM SHALL remain in hilo_unit_ctrl.
REQ-029 The multiply SHALL be an in-block 64-bit multiply of the registered operands, with no separate multiplier instance.

Verification
REQ-030 The bench SHALL cover: MULT a=0xFFFFFFFF b=2 -> after 2 edges hi=0xFFFFFFFF, lo=0xFFFFFFFE, done 1 cycle, busy 1 cycle.
REQ-031 The bench SHALL cover: MULTU same operands -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-032 The bench SHALL cover these division cases:
- DIV 7 / 0xFFFFFFFE (-2) -> lo=0xFFFFFFFD, hi=0x00000001, busy high exactly 33 cycles.
- DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 0xFFFFFFFF / 0x10 -> lo=0x0FFFFFFF, hi=0x0000000F.
REQ-033 The bench SHALL cover: DIV with b=0 after MTHI 0x1234 -> hi=0x1234 unchanged, busy never high, done 1 cycle after acceptance.
REQ-034 The bench SHALL cover: MTLO 0xA5A5A5A5 issued while busy during a DIV -> ignored; the final lo equals the DIV quotient.
REQ-035 The bench SHALL cover: rst pulsed at DIV iteration 10 -> hi=lo=0, busy=0, and a MULT 3*5 on the next edge yields lo=15, hi=0.
